pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/hazard_pkg.sv | 17 +
 rtl/pipeline_hazard_ctrl_if.sv | 47 ++++
 rtl/hazard_perf_cnt.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_e     : controller FSM state (RUN / MEM_WAIT)
//   REG_AW_DEFAULT : default register-index width
//   WAIT_CNT_W     : width of the MEM_WAIT cycle counter
//   PERF_CNT_W     : width of the optional performance counters
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    localparam int unsigned REG_AW_DEFAULT = 5;
    localparam int unsigned WAIT_CNT_W     = 8;
    localparam int unsigned PERF_CNT_W     = 32;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
//   master : pipeline side, drives stage status, receives load enables / flushes
//   slave  : hazard controller side
// Stage status : id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_MemRead,
//                branch_taken, dmem_req, dmem_ack
// Controls     : pc_write, ifid_write, idex_write, exmem_write,
//                ifid_flush, idex_flush, memwb_flush, timeout_err
interface pipeline_hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT
);

    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_MemRead;
    logic              branch_taken;
    logic              dmem_req;
    logic              dmem_ack;

    logic              pc_write;
    logic              ifid_write;
    logic              idex_write;
    logic              exmem_write;
    logic              ifid_flush;
    logic              idex_flush;
    logic              memwb_flush;
    logic              timeout_err;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_MemRead,
               branch_taken, dmem_req, dmem_ack,
        input  pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, memwb_flush, timeout_err
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_MemRead,
               branch_taken, dmem_req, dmem_ack,
        output pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, memwb_flush, timeout_err
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Hazard performance counters (free-running, wrapping).
//   clk, reset_n     : clock, asynchronous active-low reset
//   i_stall          : one stall cycle happened (load-use or MEM_WAIT)
//   i_flush          : one branch flush happened
//   o_stall_cycles   : total stall cycles
//   o_flush_count    : total branch flushes
module hazard_perf_cnt
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_stall,
    input  logic                  i_flush,
    output logic [PERF_CNT_W-1:0] o_stall_cycles,
    output logic [PERF_CNT_W-1:0] o_flush_count
);

    logic [PERF_CNT_W-1:0] r_stall_cycles;
    logic [PERF_CNT_W-1:0] r_flush_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (i_stall) begin
                r_stall_cycles <= r_stall_cycles + PERF_CNT_W'(1);
            end
            if (i_flush) begin
                r_flush_count <= r_flush_count + PERF_CNT_W'(1);
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, taken-branch squash and
// data-memory wait freeze with a wait timeout.
//   clk, reset_n : clock, asynchronous active-low reset
//   hz (slave)   : stage status in, register load enables / flushes out,
//                  sticky timeout_err out
//   stall_cycles, flush_count : 32-bit perf counters, present only when
//                  HAZARD_PERF_CNT_EN is defined
// Priority: memory freeze > taken branch > load-use. Enables and flushes are
// combinational from the state and the current inputs; while reset_n is low
// every enable is 0 and every flush is 1.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int unsigned REG_AW       = REG_AW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    pipeline_hazard_ctrl_if.slave    hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0]    stall_cycles,
    output logic [PERF_CNT_W-1:0]    flush_count
`endif
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(WAIT_TIMEOUT);

    hz_state_e             r_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_timeout_err;

    logic [REG_AW-1:0]     w_rs1;
    logic [REG_AW-1:0]     w_rs2;
    logic [REG_AW-1:0]     w_rd;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_inc;
    logic                  w_load_use;
    logic                  w_timeout;
    logic                  w_mem_freeze;
    logic                  w_branch_flush;
    logic                  w_lu_stall;

    assign w_rs1 = hz.id_rs1;
    assign w_rs2 = hz.id_rs2;
    assign w_rd  = hz.ex_rd;

    always_comb begin
        w_load_use = hz.ex_MemRead && (w_rd != '0) &&
                     ((hz.id_uses_rs1 && (w_rs1 == w_rd)) ||
                      (hz.id_uses_rs2 && (w_rs2 == w_rd)));

        w_wait_cnt_inc = r_wait_cnt + WAIT_CNT_W'(1);

        // The MEM_WAIT cycle on which the counter reaches WAIT_TIMEOUT gives
        // up: the freeze is released that same cycle. An ack always wins.
        w_timeout = (r_state == MEM_WAIT) && !hz.dmem_ack &&
                    (w_wait_cnt_inc == TIMEOUT_VAL);

        if (r_state == RUN) begin
            w_mem_freeze = hz.dmem_req && !hz.dmem_ack;
        end else begin
            w_mem_freeze = !hz.dmem_ack && !w_timeout;
        end

        // Branch and load-use are only acted on when the pipe is moving;
        // while frozen EX/ID hold, so they present again afterwards.
        w_branch_flush = !w_mem_freeze && hz.branch_taken;
        w_lu_stall     = !w_mem_freeze && !hz.branch_taken && w_load_use;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (hz.dmem_req && !hz.dmem_ack) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (hz.dmem_ack) begin
                        r_state <= RUN;
                    end else begin
                        r_wait_cnt <= w_wait_cnt_inc;
                        if (w_timeout) begin
                            r_state       <= RUN;
                            r_timeout_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always_comb begin
        hz.pc_write    = 1'b1;
        hz.ifid_write  = 1'b1;
        hz.idex_write  = 1'b1;
        hz.exmem_write = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_flush  = 1'b0;
        hz.memwb_flush = 1'b0;
        hz.timeout_err = r_timeout_err;

        if (!reset_n) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.exmem_write = 1'b0;
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.memwb_flush = 1'b1;
        end else if (w_mem_freeze) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.exmem_write = 1'b0;
            hz.memwb_flush = 1'b1;
        end else if (w_branch_flush) begin
            // Squash the two younger instructions in IF/ID and ID/EX.
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
        end else if (w_lu_stall) begin
            hz.pc_write   = 1'b0;
            hz.ifid_write = 1'b0;
            hz.idex_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic w_perf_stall;

    assign w_perf_stall = w_lu_stall || (r_state == MEM_WAIT);

    hazard_perf_cnt u_perf_cnt (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_stall        (w_perf_stall),
        .i_flush        (w_branch_flush),
        .o_stall_cycles (stall_cycles),
        .o_flush_count  (flush_count)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (WAIT_TIMEOUT = 4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Control outputs are packed as
// {pc_write, ifid_write, idex_write, exmem_write,
//  ifid_flush, idex_flush, memwb_flush, timeout_err}.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       rn;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       req;
        logic       ack;
    } stim_t;

    localparam logic [7:0] RUN_OK   = 8'b1111_0000;
    localparam logic [7:0] RESET_O  = 8'b0000_1110;
    localparam logic [7:0] LU_STALL = 8'b0011_0100;
    localparam logic [7:0] BRANCH   = 8'b1111_1100;
    localparam logic [7:0] FREEZE   = 8'b0000_0010;
    localparam logic [7:0] ERR      = 8'b0000_0001;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    stim_t      pend_s[$];
    logic [7:0] pend_e[$];
    logic [7:0] sb_q[$];

    stim_t s_idle, s_lu, s_lu_rd0, s_rd0_zero, s_rs1_unused, s_not_load;
    stim_t s_rs2_unused, s_lu_rs2, s_br, s_lu_br, s_req, s_req_ack;
    stim_t s_req_haz, s_rst_haz, s_rst_req, s_rst_idle;

    pipeline_hazard_ctrl_if #(.REG_AW(5)) hz_if ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    pipeline_hazard_ctrl #(
        .WAIT_TIMEOUT (4),
        .REG_AW       (5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .hz           (hz_if)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic mr, input logic br, input logic req,
                                 input logic ack);
        stim_t s;
        s.rn  = 1'b1;
        s.rs1 = rs1;
        s.rs2 = rs2;
        s.u1  = u1;
        s.u2  = u2;
        s.rd  = rd;
        s.mr  = mr;
        s.br  = br;
        s.req = req;
        s.ack = ack;
        return s;
    endfunction

    function automatic logic [7:0] ctl_vec();
        return {hz_if.pc_write, hz_if.ifid_write, hz_if.idex_write, hz_if.exmem_write,
                hz_if.ifid_flush, hz_if.idex_flush, hz_if.memwb_flush, hz_if.timeout_err};
    endfunction

    task automatic drive(input stim_t s);
        reset_n            = s.rn;
        hz_if.id_rs1       = s.rs1;
        hz_if.id_rs2       = s.rs2;
        hz_if.id_uses_rs1  = s.u1;
        hz_if.id_uses_rs2  = s.u2;
        hz_if.ex_rd        = s.rd;
        hz_if.ex_MemRead   = s.mr;
        hz_if.branch_taken = s.br;
        hz_if.dmem_req     = s.req;
        hz_if.dmem_ack     = s.ack;
    endtask

    task automatic add(input stim_t s, input logic [7:0] e);
        pend_s.push_back(s);
        pend_e.push_back(e);
    endtask

    task automatic test_reset();
        logic [7:0] got, want;
        int idx = 0;
        add(s_rst_haz, RESET_O);
        add(s_rst_haz, RESET_O);
        add(s_idle, RUN_OK);
        while (pend_s.size() != 0) begin
            drive(pend_s.pop_front());
            sb_q.push_back(pend_e.pop_front());
            @(negedge clk);
            got  = ctl_vec();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL reset[%0d]: got %b want %b", idx, got, want);
            else n_pass++;
            idx++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_hazard();
        logic [7:0] got, want;
        int idx = 0;
        add(s_lu_rd0, RUN_OK);
        add(s_rd0_zero, RUN_OK);
        add(s_rs1_unused, RUN_OK);
        add(s_not_load, RUN_OK);
        add(s_rs2_unused, RUN_OK);
        add(s_lu_rs2, LU_STALL);
        add(s_req_ack, RUN_OK);
        add(s_idle, RUN_OK);
        while (pend_s.size() != 0) begin
            drive(pend_s.pop_front());
            sb_q.push_back(pend_e.pop_front());
            @(negedge clk);
            got  = ctl_vec();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL no_hazard[%0d]: got %b want %b", idx, got, want);
            else n_pass++;
            idx++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        logic [7:0] got, want;
        int idx = 0;
        add(s_lu, LU_STALL);
        add(s_idle, RUN_OK);
        while (pend_s.size() != 0) begin
            drive(pend_s.pop_front());
            sb_q.push_back(pend_e.pop_front());
            @(negedge clk);
            got  = ctl_vec();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL load_use[%0d]: got %b want %b", idx, got, want);
            else n_pass++;
            idx++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [7:0] got, want;
        int idx = 0;
        add(s_lu_br, BRANCH);
        add(s_br, BRANCH);
        add(s_idle, RUN_OK);
        while (pend_s.size() != 0) begin
            drive(pend_s.pop_front());
            sb_q.push_back(pend_e.pop_front());
            @(negedge clk);
            got  = ctl_vec();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL branch[%0d]: got %b want %b", idx, got, want);
            else n_pass++;
            idx++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        logic [7:0] got, want;
        int idx = 0;
        for (int i = 0; i < 4; i++) add(s_req_haz, FREEZE);
        add(s_req_ack, RUN_OK);
        add(s_lu_br, BRANCH);
        add(s_idle, RUN_OK);
        while (pend_s.size() != 0) begin
            drive(pend_s.pop_front());
            sb_q.push_back(pend_e.pop_front());
            @(negedge clk);
            got  = ctl_vec();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL mem_wait[%0d]: got %b want %b", idx, got, want);
            else n_pass++;
            idx++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, want;
        int idx = 0;
        for (int i = 0; i < 4; i++) add(s_req, FREEZE);
        add(s_req_ack, RUN_OK);
        add(s_req, FREEZE);
        add(s_req_ack, RUN_OK);
        add(s_lu, LU_STALL);
        add(s_idle, RUN_OK);
        while (pend_s.size() != 0) begin
            drive(pend_s.pop_front());
            sb_q.push_back(pend_e.pop_front());
            @(negedge clk);
            got  = ctl_vec();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL back_to_back[%0d]: got %b want %b", idx, got, want);
            else n_pass++;
            idx++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        logic [7:0] got, want;
        int idx = 0;
        for (int i = 0; i < 4; i++) add(s_req, FREEZE);
        add(s_req, RUN_OK);
        add(s_idle, RUN_OK | ERR);
        add(s_lu_br, BRANCH | ERR);
        add(s_lu, LU_STALL | ERR);
        add(s_idle, RUN_OK | ERR);
        add(s_rst_idle, RESET_O);
        add(s_idle, RUN_OK);
        while (pend_s.size() != 0) begin
            drive(pend_s.pop_front());
            sb_q.push_back(pend_e.pop_front());
            @(negedge clk);
            got  = ctl_vec();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL timeout[%0d]: got %b want %b", idx, got, want);
            else n_pass++;
            idx++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [7:0] got, want;
        int idx = 0;
        add(s_req, FREEZE);
        add(s_req, FREEZE);
        add(s_rst_req, RESET_O);
        add(s_br, BRANCH);
        add(s_idle, RUN_OK);
        while (pend_s.size() != 0) begin
            drive(pend_s.pop_front());
            sb_q.push_back(pend_e.pop_front());
            @(negedge clk);
            got  = ctl_vec();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) $display("FAIL reset_mid_wait[%0d]: got %b want %b", idx, got, want);
            else n_pass++;
            idx++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        s_idle       = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        s_lu         = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        s_lu_rd0     = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        s_rd0_zero   = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        s_rs1_unused = mk(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        s_not_load   = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        s_rs2_unused = mk(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        s_lu_rs2     = mk(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        s_br         = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        s_lu_br      = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        s_req        = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        s_req_ack    = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        s_req_haz    = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        s_rst_haz    = s_lu_br;
        s_rst_haz.rn = 1'b0;
        s_rst_req    = s_req;
        s_rst_req.rn = 1'b0;
        s_rst_idle    = s_idle;
        s_rst_idle.rn = 1'b0;

        test_reset();
        test_no_hazard();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
